// File: rtl/icmp_pkg.sv
// Shared ICMP constants, responder state encoding and the ones-complement fold helper.
package icmp_pkg;

  localparam logic [7:0] ICMP_ECHO_REQUEST = 8'd8;
  localparam logic [7:0] ICMP_ECHO_REPLY   = 8'd0;
  localparam logic [7:0] PROTOCOLICMP      = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    RXPAY,
    CHECK,
    FOLD,
    REQ,
    STREAM,
    DROP
  } state_t;

  // Folds carries back into the low 16 bits twice; two folds are enough for any
  // sum narrower than 32 bits.
  function automatic logic [15:0] onescomp_fold(input logic [31:0] sum);
    logic [16:0] t1;
    logic [16:0] t2;
    t1 = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
    t2 = {1'b0, t1[15:0]} + {16'd0, t1[16]};
    return t2[15:0];
  endfunction

endpackage

// File: rtl/icmp_payload_ram.sv
// Simple dual-port payload buffer with a registered read port (block-RAM style).
module icmp_payload_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [0:(1<<AW)-1];

  // Write port and one-cycle registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/icmp_echo_responder.sv
// Answers ICMP Echo Requests: buffers the payload, verifies the checksum,
// builds the reply header and streams the reply once the transmit side grants.
module icmp_echo_responder
  import icmp_pkg::*;
#(
  parameter int AW         = 10,
  parameter int ACKTIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] rx_head,
  input  logic        rx_newhead,
  input  logic [7:0]  rx_data,
  input  logic        rx_dven,
  input  logic        rx_error,
  output logic [63:0] tx_head,
  output logic [7:0]  tx_data,
  output logic        tx_dven,
  output logic        request,
  output logic [7:0]  requestcode,
  input  logic        ack,
  output logic        busy,
  output logic [15:0] reply_cnt,
  output logic [15:0] drop_cnt
);

  localparam int SW = 16 + AW + 1;
  localparam logic [AW:0]   MAXLEN   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  state_t        state, state_n;
  logic [63:0]   head_q;
  logic [AW:0]   len;
  logic [AW:0]   tx_idx;
  logic [SW-1:0] sum;
  logic          drop_flag;
  logic          fold_phase;
  logic          chk_ok;
  logic [15:0]   rcsum;
  logic [31:0]   timer;
  logic          own_drop;
  logic          reply_done;
  logic          is_echo;
  logic          busy_echo;
  logic          wr_en;
  logic [15:0]   byte_word;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  assign is_echo   = (rx_head[63:56] == ICMP_ECHO_REQUEST) && (rx_head[55:48] == 8'd0);
  assign busy_echo = rx_newhead && is_echo && (state != IDLE);
  assign wr_en     = (state == RXPAY) && rx_dven && (len != MAXLEN);
  assign byte_word = len[0] ? {8'h00, rx_data} : {rx_data, 8'h00};
  assign rd_addr   = (state == STREAM) ? tx_idx[AW-1:0] + ADDR_ONE : '0;

  assign busy        = (state != IDLE);
  assign request     = (state == REQ);
  assign tx_dven     = (state == STREAM) && (len != '0);
  assign tx_data     = tx_dven ? rd_data : 8'h00;
  assign requestcode = PROTOCOLICMP;

  icmp_payload_ram #(.AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (len[AW-1:0]),
    .wr_data (rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State register; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode plus the drop/reply events that feed the counters.
  always_comb begin
    state_n    = state;
    own_drop   = 1'b0;
    reply_done = 1'b0;
    case (state)
      IDLE:   if (rx_newhead) state_n = is_echo ? RXPAY : DROP;
      RXPAY:  if (!rx_dven) state_n = CHECK;
      CHECK: begin
        if (drop_flag) begin
          state_n  = IDLE;
          own_drop = 1'b1;
        end else begin
          state_n = FOLD;
        end
      end
      FOLD: begin
        if (fold_phase) begin
          if (chk_ok) begin
            state_n = REQ;
          end else begin
            state_n  = IDLE;
            own_drop = 1'b1;
          end
        end
      end
      REQ: begin
        if (ack) begin
          state_n = STREAM;
        end else if (timer == 32'(ACKTIMEOUT - 1)) begin
          state_n  = IDLE;
          own_drop = 1'b1;
        end
      end
      STREAM: begin
        if ((len == '0) || (tx_idx + LEN_ONE == len)) begin
          state_n    = IDLE;
          reply_done = 1'b1;
        end
      end
      DROP:    if (!rx_dven) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Payload accumulation, checksum folding, reply header build and stream indexing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      len        <= '0;
      tx_idx     <= '0;
      sum        <= '0;
      drop_flag  <= 1'b0;
      fold_phase <= 1'b0;
      chk_ok     <= 1'b0;
      rcsum      <= '0;
      timer      <= '0;
      tx_head    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_newhead) begin
            head_q    <= rx_head;
            len       <= '0;
            sum       <= '0;
            drop_flag <= rx_error;
          end
        end
        RXPAY: begin
          if (rx_error) drop_flag <= 1'b1;
          if (rx_dven) begin
            if (len == MAXLEN) begin
              drop_flag <= 1'b1;
            end else begin
              len <= len + LEN_ONE;
              sum <= sum + SW'(byte_word);
            end
          end
        end
        CHECK: begin
          sum <= sum + SW'(head_q[63:48]) + SW'(head_q[47:32])
                     + SW'(head_q[31:16]) + SW'(head_q[15:0]);
          fold_phase <= 1'b0;
        end
        FOLD: begin
          if (!fold_phase) begin
            chk_ok     <= (onescomp_fold(32'(sum)) == 16'hFFFF);
            rcsum      <= ~onescomp_fold(32'(sum - SW'(16'h0800) - SW'(head_q[47:32])));
            fold_phase <= 1'b1;
          end else if (chk_ok) begin
            tx_head <= {ICMP_ECHO_REPLY, 8'h00, rcsum, head_q[31:0]};
            timer   <= '0;
          end
        end
        REQ: begin
          timer  <= timer + 32'd1;
          tx_idx <= '0;
        end
        STREAM: tx_idx <= tx_idx + LEN_ONE;
        default: ;
      endcase
    end
  end

  // Reply and drop counters; a busy-time echo head can coincide with a packet drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reply_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      reply_cnt <= reply_cnt + 16'(reply_done);
      drop_cnt  <= drop_cnt + 16'(own_drop) + 16'(busy_echo);
    end
  end

endmodule

// File: tb/tb_icmp_echo_responder.sv
// Randomised scoreboard bench for the ICMP echo responder.
module tb_icmp_echo_responder;

  localparam int AW         = 6;
  localparam int ACKTIMEOUT = 16;
  localparam int MAXLEN     = 1 << AW;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] rx_head = '0;
  logic        rx_newhead = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_dven = 1'b0;
  logic        rx_error = 1'b0;
  logic [63:0] tx_head;
  logic [7:0]  tx_data;
  logic        tx_dven;
  logic        request;
  logic [7:0]  requestcode;
  logic        ack = 1'b0;
  logic        busy;
  logic [15:0] reply_cnt;
  logic [15:0] drop_cnt;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_head[$];
  logic [7:0]  exp_byte[$];
  logic [15:0] exp_reply = '0;
  logic [15:0] exp_drop = '0;
  logic [7:0]  pay[$];
  logic        req_prev = 1'b0;

  icmp_echo_responder #(.AW(AW), .ACKTIMEOUT(ACKTIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_head     (rx_head),
    .rx_newhead  (rx_newhead),
    .rx_data     (rx_data),
    .rx_dven     (rx_dven),
    .rx_error    (rx_error),
    .tx_head     (tx_head),
    .tx_data     (tx_data),
    .tx_dven     (tx_dven),
    .request     (request),
    .requestcode (requestcode),
    .ack         (ack),
    .busy        (busy),
    .reply_cnt   (reply_cnt),
    .drop_cnt    (drop_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Internet checksum arithmetic: 16-bit words added with end-around carry.
  function automatic logic [15:0] ones_sum(input logic [15:0] w[$]);
    int unsigned s;
    s = 0;
    foreach (w[i]) begin
      s = s + 32'(w[i]);
      s = (s & 32'hFFFF) + (s >> 16);
    end
    return s[15:0];
  endfunction

  // Payload as big-endian words, odd tail padded with a zero low byte.
  function automatic void payload_words(output logic [15:0] w[$]);
    w.delete();
    for (int i = 0; i < pay.size(); i += 2)
      w.push_back({pay[i], (i + 1 < pay.size()) ? pay[i+1] : 8'h00});
  endfunction

  function automatic logic [15:0] good_csum(input logic [31:0] rest);
    logic [15:0] w[$];
    payload_words(w);
    w.push_back(16'h0800);
    w.push_back(rest[31:16]);
    w.push_back(rest[15:0]);
    return ~ones_sum(w);
  endfunction

  task automatic fill_random(input int n);
    pay.delete();
    repeat (n) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  // Monitor: pops the scoreboard whenever the DUT raises a request or presents a byte.
  always @(negedge clk) begin
    if (!reset) begin
      req_prev <= 1'b0;
    end else begin
      if (request && !req_prev) begin
        if (exp_head.size() == 0) checkOutput("unexpected request", 64'(request), 64'd0);
        else checkOutput("tx_head", tx_head, exp_head.pop_front());
      end
      if (tx_dven) begin
        if (exp_byte.size() == 0) checkOutput("unexpected tx_dven", 64'(tx_dven), 64'd0);
        else checkOutput("tx_data", 64'(tx_data), 64'(exp_byte.pop_front()));
      end
      req_prev <= request;
    end
  end

  // ack_mode: 0 grant after ack_delay, 1 never grant, 2 reset after two streamed bytes.
  // busy_head: 0 none, 1 echo head while busy, 2 non-echo head while busy.
  task automatic applyStimulus(input logic [7:0] typ, input logic [7:0] code, input logic [15:0] csum,
                               input logic [31:0] rest, input int err_idx, input int ack_mode,
                               input int ack_delay, input int busy_head);
    int n;
    int t;
    int run;
    bit is_echo;
    bit accept;
    logic [15:0] pw[$];
    logic [15:0] w[$];
    logic [15:0] rcs;
    n = pay.size();
    is_echo = (typ == 8'd8) && (code == 8'd0);
    payload_words(pw);
    w = pw;
    w.push_back({typ, code});
    w.push_back(csum);
    w.push_back(rest[31:16]);
    w.push_back(rest[15:0]);
    accept = is_echo && !(err_idx >= 0 && err_idx < n) && (n <= MAXLEN) && (ones_sum(w) == 16'hFFFF);
    w = pw;
    w.push_back(rest[31:16]);
    w.push_back(rest[15:0]);
    rcs = ~ones_sum(w);
    if (accept) begin
      exp_head.push_back({16'h0000, rcs, rest});
      if (ack_mode != 1) foreach (pay[i]) exp_byte.push_back(pay[i]);
    end

    step();
    rx_head = {typ, code, csum, rest};
    rx_newhead = 1'b1;
    step();
    rx_newhead = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_dven = 1'b1;
      rx_data = pay[i];
      rx_error = (i == err_idx);
      step();
    end
    rx_dven = 1'b0;
    rx_error = 1'b0;
    rx_data = 8'h00;
    if (!is_echo) return;

    if (accept) begin
      t = 0;
      while (!request && t < 50) begin step(); t++; end
      checkOutput("request asserted", 64'(request), 64'd1);
      if (busy_head != 0) begin
        rx_head = {(busy_head == 1) ? 8'd8 : 8'd13, 8'd0, 48'h0};
        rx_newhead = 1'b1;
        step();
        rx_newhead = 1'b0;
        if (busy_head == 1) exp_drop++;
      end
      if (ack_mode == 1) begin
        run = 0;
        while (request && run < 100) begin run++; step(); end
        checkOutput("request hold cycles", 64'(run), 64'(ACKTIMEOUT));
        exp_drop++;
      end else begin
        repeat (ack_delay) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        if (ack_mode == 2) begin
          step();
          step();
          reset = 1'b0;
          #1;
          checkOutput("reset tx_dven", 64'(tx_dven), 64'd0);
          checkOutput("reset request", 64'(request), 64'd0);
          checkOutput("reset busy", 64'(busy), 64'd0);
          checkOutput("reset reply_cnt", 64'(reply_cnt), 64'd0);
          checkOutput("reset drop_cnt", 64'(drop_cnt), 64'd0);
          exp_head.delete();
          exp_byte.delete();
          exp_reply = '0;
          exp_drop = '0;
          step();
          reset = 1'b1;
          return;
        end
        run = 0;
        while (tx_dven && run < 300) begin run++; step(); end
        checkOutput("stream length", 64'(run), 64'(n));
        exp_reply++;
      end
    end else begin
      exp_drop++;
    end
    t = 0;
    while (busy && t < 300) begin step(); t++; end
    checkOutput("busy low", 64'(busy), 64'd0);
    checkOutput("reply_cnt", 64'(reply_cnt), 64'(exp_reply));
    checkOutput("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
  endtask

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed cases followed by randomised traffic.
  initial begin
    logic [31:0] rest;
    logic [15:0] csum;
    logic [7:0]  typ;
    int n;
    int err;
    repeat (3) step();
    checkOutput("reset tx_head", tx_head, 64'd0);
    checkOutput("reset tx_dven", 64'(tx_dven), 64'd0);
    checkOutput("reset request", 64'(request), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset reply_cnt", 64'(reply_cnt), 64'd0);
    checkOutput("reset drop_cnt", 64'(drop_cnt), 64'd0);
    checkOutput("requestcode", 64'(requestcode), 64'h01);
    reset = 1'b1;

    pay = {8'h61, 8'h62, 8'h63, 8'h64};
    applyStimulus(8'd8, 8'd0, 16'h2104, 32'h1234_0001, -1, 0, 1, 0);
    applyStimulus(8'd8, 8'd0, 16'h2105, 32'h1234_0001, -1, 0, 0, 0);
    pay = {8'h61, 8'h62, 8'h63};
    applyStimulus(8'd8, 8'd0, 16'h6EB7, 32'hC4E5_0000, -1, 0, 0, 0);

    fill_random(5);
    applyStimulus(8'd13, 8'd0, 16'h1111, 32'h0, -1, 0, 0, 0);
    pay = {8'h61, 8'h62, 8'h63, 8'h64};
    applyStimulus(8'd8, 8'd0, 16'h2104, 32'h1234_0001, -1, 0, 2, 0);

    fill_random(7);
    applyStimulus(8'd8, 8'd0, good_csum(32'hABCD_0002), 32'hABCD_0002, -1, 1, 0, 0);

    fill_random(6);
    applyStimulus(8'd8, 8'd0, good_csum(32'h5555_0003), 32'h5555_0003, -1, 2, 0, 0);

    fill_random(MAXLEN);
    applyStimulus(8'd8, 8'd0, good_csum(32'h0102_0304), 32'h0102_0304, -1, 0, 0, 0);
    fill_random(MAXLEN + 1);
    applyStimulus(8'd8, 8'd0, good_csum(32'h0102_0305), 32'h0102_0305, -1, 0, 0, 0);
    pay.delete();
    applyStimulus(8'd8, 8'd0, good_csum(32'h7777_0009), 32'h7777_0009, -1, 0, 0, 0);
    fill_random(10);
    applyStimulus(8'd8, 8'd0, good_csum(32'h2222_0001), 32'h2222_0001, 4, 0, 0, 0);
    fill_random(9);
    applyStimulus(8'd8, 8'd0, good_csum(32'h3333_0001), 32'h3333_0001, -1, 0, 2, 1);
    fill_random(9);
    applyStimulus(8'd8, 8'd0, good_csum(32'h3333_0002), 32'h3333_0002, -1, 0, 2, 2);

    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(0, MAXLEN + 6);
      fill_random(n);
      rest = $urandom;
      typ = ($urandom_range(0, 7) == 0) ? 8'd13 : 8'd8;
      csum = good_csum(rest);
      if ($urandom_range(0, 5) == 0) csum = csum ^ 16'h0010;
      err = ($urandom_range(0, 9) == 0 && n > 0) ? int'($urandom_range(0, n - 1)) : -1;
      applyStimulus(typ, 8'd0, csum, rest, err, 0, int'($urandom_range(0, 4)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    end

    repeat (5) step();
    checkOutput("pending heads", 64'(exp_head.size()), 64'd0);
    checkOutput("pending bytes", 64'(exp_byte.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icmp_echo_responder.md
Name: icmp_echo_responder

Overview:
- Client-side endpoint of the ICMP link: consumes the parsed ICMP receive stream (header + payload bytes) and answers Echo Requests (type 8, code 0) with Echo Replies (type 0).
- Buffers the payload, verifies the received checksum, computes the reply checksum, raises a transmit request, then streams the reply header and payload back into the ICMP transmit path.
- Sits directly above the ICMP-over-IPv4 adapter, on the ICMP link's rx/tx bundles.

Parameters:
- AW, 10, payload buffer address width; maximum echo payload is 2^AW bytes.
- ACKTIMEOUT, 65535, cycles to wait for ack before the reply is abandoned.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- rx_head  input  64  {type,code,checksum,restofheader}, valid while rx_newhead is high.
- rx_newhead  input  1  one-cycle pulse; header complete, payload follows.
- rx_data  input  8  payload byte.
- rx_dven  input  1  payload byte valid; payload is contiguous and ends when this falls.
- rx_error  input  1  upstream error flag for the current packet.
- tx_head  output  64  reply header; stable from request assertion until the reply finishes.
- tx_data  output  8  reply payload byte.
- tx_dven  output  1  reply payload byte valid.
- request  output  1  transmit request, held until ack.
- requestcode  output  8  constant 8'h01.
- ack  input  1  one-cycle grant from the transmit side.
- busy  output  1  high in any state other than IDLE.
- reply_cnt  output  16  replies sent; wraps at 2^16.
- drop_cnt  output  16  packets dropped; wraps at 2^16.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0; reset mid-operation aborts immediately.
- States: IDLE, RXPAY, CHECK, FOLD, REQ, STREAM, DROP.
- IDLE: on rx_newhead, latch rx_head.
  - Type 8 and code 0 → RXPAY.
  - Any other type/code → DROP without counting.
- RXPAY: each rx_dven cycle writes rx_data to buffer[len], increments len, and adds the byte into a (16+AW+1)-bit sum.
  - Byte pairing is big-endian: even index is the high byte, odd index is the low byte.
  - An odd final byte is padded with a 0x00 low byte.
  - End of payload: rx_dven low while rx_dven was seen high, or rx_dven still low on the first cycle after rx_newhead (zero-length payload).
  - At end of payload → CHECK.
  - rx_error at any point, or len reaching 2^AW with rx_dven still high: set drop flag and keep consuming until rx_dven falls.
- CHECK: adds header words type/code, checksum, rest[31:16], rest[15:0] to the sum.
  - Drop flag set → IDLE, drop_cnt+1.
  - Otherwise → FOLD.
- FOLD, two cycles:
  - Fold carries into 16 bits twice to get S.
  - Verify S == 16'hFFFF; on mismatch → IDLE, drop_cnt+1.
  - Reply checksum = ~fold(sum − 16'h0800 − received checksum), computed as a full recompute with type 0 and the checksum field zeroed.
  - tx_head = {8'h00, 8'h00, replycsum, restofheader}.
  - → REQ.
- REQ: request=1; timer counts.
  - ack → STREAM, request=0.
  - Timer reaches ACKTIMEOUT → IDLE, drop_cnt+1.
- STREAM: starting the cycle after ack, drive len bytes from the buffer, one per cycle, with tx_dven contiguous and no gaps.
  - Buffer read latency is absorbed by prefetching byte 0 in REQ.
  - After the last byte, tx_dven=0, reply_cnt+1 → IDLE.
  - Zero-length payload: no tx_dven; reply_cnt+1 the cycle after ack.
- DROP: ignore input until rx_dven falls (or the zero-length rule applies) → IDLE.
- rx_newhead while busy: ignored; drop_cnt+1 only if that head is an echo request.
- ack outside REQ: ignored.

Decomposition:
- Shared package icmp_pkg:
  - ICMP_ECHO_REQUEST=8, ICMP_ECHO_REPLY=0, PROTOCOLICMP=8'h01.
  - State enum.
  - Function onescomp_fold(sum) returning 16 bits.
- One sub-module: icmp_payload_ram, a simple dual-port RAM of 2^AW × 8 with one-cycle registered read, BRAM-inferable.

Test Plan:
- Echo request, id 0x1234, seq 0x0001, payload 61 62 63 64, checksum 0x2104 → request asserted; tx_head=64'h0000_2904_1234_0001; tx_data 61 62 63 64 on four consecutive cycles after ack; reply_cnt=1.
- Same packet with checksum 0x2105 → no request; drop_cnt=1; busy returns low.
- Odd payload 61 62 63, checksum 0x6EB7 (sum pads 0x6300) → reply checksum 0x76B7; three bytes streamed.
- Type 13 (timestamp) header → no request, drop_cnt unchanged; a second echo request sent 1 cycle after rx_dven falls is answered.
- Valid request with ack never given, ACKTIMEOUT=16 → request high for 16 cycles then low; drop_cnt=1.
- reset driven low during STREAM after byte 2 → tx_dven=0 and request=0 at once; counters 0; next valid request is answered normally.
